// File: rtl/fft_delay_line_if.sv
// Beat-level bus of the FFT delay line: input beats and flush requests in,
// the oldest stored beat plus butterfly pairing and status out.
interface fft_delay_line_if #(
    parameter int DATA_WIDTH = 9,
    parameter int LANES      = 16
);
    logic                                   din_valid;
    logic signed [LANES-1:0][DATA_WIDTH-1:0] din_i;
    logic signed [LANES-1:0][DATA_WIDTH-1:0] din_q;
    logic                                   flush;
    logic signed [LANES-1:0][DATA_WIDTH-1:0] dout_i;
    logic signed [LANES-1:0][DATA_WIDTH-1:0] dout_q;
    logic                                   dout_valid;
    logic                                   bfly_en;
    logic                                   busy;
    logic                                   ovr_err;

    modport master (
        output din_valid, din_i, din_q, flush,
        input  dout_i, dout_q, dout_valid, bfly_en, busy, ovr_err
    );

    modport slave (
        input  din_valid, din_i, din_q, flush,
        output dout_i, dout_q, dout_valid, bfly_en, busy, ovr_err
    );
endinterface

// File: rtl/fft_delay_line.sv
// Beat-wide complex delay line of DEPTH samples feeding a radix-2 FFT stage;
// pairs each new beat with the beat BLOCKS advances older and drains on flush.
module fft_delay_line #(
    parameter int DATA_WIDTH = 9,
    parameter int LANES      = 16,
    parameter int DEPTH      = 256
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            clr,
    fft_delay_line_if.slave bus
);
    localparam int BLOCKS = DEPTH / LANES;
    localparam int PW     = $clog2(2 * BLOCKS);

    if ((DEPTH % LANES) != 0 || BLOCKS < 2 || (BLOCKS & (BLOCKS - 1)) != 0) begin : g_param_check
        $fatal(1, "fft_delay_line: DEPTH must be LANES times a power of two >= 2");
    end

    typedef logic signed [LANES-1:0][DATA_WIDTH-1:0] beat_t;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    beat_t             stg_i [BLOCKS];
    beat_t             stg_q [BLOCKS];
    logic [BLOCKS-1:0] tag;
    logic [PW-1:0]     phase;
    state_t            state;
    logic              busy_q;
    logic              ovr_err_q;

    logic adv_in;
    logic adv;
    logic drop;

    // A flush request in RUN wins over a beat arriving in the same cycle.
    assign adv_in = bus.din_valid && (state == IDLE || (state == RUN && !bus.flush));
    assign adv    = adv_in || (state == FLUSH);
    assign drop   = bus.din_valid && (state == FLUSH || (state == RUN && bus.flush));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the storage array is reset on purpose: a flush or reset must leave
            // dout at zero, so this line cannot be mapped to a reset-less RAM.
            stg_i     <= '{default: '0};
            stg_q     <= '{default: '0};
            tag       <= '0;
            phase     <= '0;
            state     <= IDLE;
            busy_q    <= 1'b0;
            ovr_err_q <= 1'b0;
        end else if (clr) begin
            stg_i     <= '{default: '0};
            stg_q     <= '{default: '0};
            tag       <= '0;
            phase     <= '0;
            state     <= IDLE;
            busy_q    <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            if (adv) begin
                for (int k = BLOCKS - 1; k > 0; k--) begin
                    stg_i[k] <= stg_i[k-1];
                    stg_q[k] <= stg_q[k-1];
                end
                stg_i[0] <= adv_in ? beat_t'(bus.din_i) : '0;
                stg_q[0] <= adv_in ? beat_t'(bus.din_q) : '0;
                tag      <= {tag[BLOCKS-2:0], adv_in};
            end

            if (adv_in) begin
                phase <= phase + 1'b1;
            end

            if (drop) begin
                ovr_err_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.din_valid) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state  <= FLUSH;
                        busy_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    // Only stage BLOCKS-1 may still be tagged; this advance empties it.
                    if (tag[BLOCKS-2:0] == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        phase  <= '0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout_i     = stg_i[BLOCKS-1];
    assign bus.dout_q     = stg_q[BLOCKS-1];
    assign bus.dout_valid = tag[BLOCKS-1];
    assign bus.busy       = busy_q;
    assign bus.ovr_err    = ovr_err_q;
    assign bus.bfly_en    = bus.din_valid && phase[PW-1] && (state != FLUSH);
endmodule

// File: tb/tb_fft_delay_line.sv
// Directed bench for fft_delay_line: default geometry plus two parameter sweeps,
// all expectations computed from the beat numbering b*LANES+lane.
module tb_fft_delay_line;
    logic clk = 1'b0;
    logic rstn;
    logic clr;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    fft_delay_line_if #(.DATA_WIDTH(9), .LANES(16)) if0 ();
    fft_delay_line_if #(.DATA_WIDTH(9), .LANES(4))  if1 ();
    fft_delay_line_if #(.DATA_WIDTH(9), .LANES(8))  if2 ();

    fft_delay_line #(.DATA_WIDTH(9), .LANES(16), .DEPTH(256)) u0 (.clk(clk), .rstn(rstn), .clr(clr), .bus(if0));
    fft_delay_line #(.DATA_WIDTH(9), .LANES(4),  .DEPTH(32))  u1 (.clk(clk), .rstn(rstn), .clr(clr), .bus(if1));
    fft_delay_line #(.DATA_WIDTH(9), .LANES(8),  .DEPTH(512)) u2 (.clk(clk), .rstn(rstn), .clr(clr), .bus(if2));

    task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0][8:0] beat16(input int b, input bit q);
        logic [15:0][8:0] r;
        int v;
        for (int j = 0; j < 16; j++) begin
            v    = b * 16 + j;
            r[j] = q ? 9'(-v) : 9'(v);
        end
        return r;
    endfunction

    function automatic logic [3:0][8:0] pat4(input int b);
        logic [3:0][8:0] r;
        for (int j = 0; j < 4; j++) r[j] = 9'(b * 4 + j);
        return r;
    endfunction

    function automatic logic [7:0][8:0] pat8(input int b);
        logic [7:0][8:0] r;
        for (int j = 0; j < 8; j++) r[j] = 9'(b * 8 + j);
        return r;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive0(input logic v, input int b, input logic fl);
        @(negedge clk);
        if0.din_valid = v;
        if0.din_i     = beat16(b, 1'b0);
        if0.din_q     = beat16(b, 1'b1);
        if0.flush     = fl;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn          = 1'b0;
        clr           = 1'b0;
        if0.din_valid = 1'b0;
        if0.flush     = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  idx;
        bit  done;
        rstn = 1'b1;
        clr  = 1'b0;
        if0.din_valid = 1'b0; if0.flush = 1'b0; if0.din_i = '0; if0.din_q = '0;
        if1.din_valid = 1'b0; if1.flush = 1'b0; if1.din_i = '0; if1.din_q = '0;
        if2.din_valid = 1'b0; if2.flush = 1'b0; if2.din_i = '0; if2.din_q = '0;

        // Reset state, then 33 back-to-back beats.
        do_reset();
        check("rst_dv",    if0.dout_valid, 1'b0);
        check("rst_di",    {if0.dout_i}, '0);
        check("rst_busy",  if0.busy, 1'b0);
        check("rst_ovr",   if0.ovr_err, 1'b0);
        check("rst_phase", u0.phase, 0);
        for (int b = 0; b <= 32; b++) begin
            drive0(1'b1, b, 1'b0);
            check("t1_bfly", if0.bfly_en, (b >= 16 && b < 32));
            check("t1_dv",   if0.dout_valid, (b >= 16));
            if (b >= 16) begin
                check("t1_di", {if0.dout_i}, beat16(b - 16, 1'b0));
                check("t1_dq", {if0.dout_q}, beat16(b - 16, 1'b1));
            end
        end

        // Beats every third cycle; two idle cycles must hold dout and phase.
        do_reset();
        for (int b = 0; b < 32; b++) begin
            drive0(1'b1, b, 1'b0);
            check("t2_bfly", if0.bfly_en, (b >= 16));
            check("t2_dv",   if0.dout_valid, (b >= 16));
            if (b >= 16) check("t2_di", {if0.dout_i}, beat16(b - 16, 1'b0));
            for (int g = 0; g < 2; g++) begin
                drive0(1'b0, b, 1'b0);
                check("t2_idle_bfly",  if0.bfly_en, 1'b0);
                check("t2_idle_dv",    if0.dout_valid, (b >= 15));
                check("t2_idle_di",    {if0.dout_i}, (b >= 15) ? beat16(b - 15, 1'b0) : '0);
                check("t2_idle_phase", u0.phase, (b + 1) % 32);
            end
        end

        // Five beats then flush: beats 0..4 drain out, 16 busy cycles, back to IDLE.
        do_reset();
        for (int b = 0; b < 5; b++) drive0(1'b1, b, 1'b0);
        drive0(1'b0, 0, 1'b1);
        check("t3_pre_phase", u0.phase, 5);
        check("t3_pre_busy",  if0.busy, 1'b0);
        for (int s = 0; s <= 16; s++) begin
            drive0(1'b0, 0, 1'b0);
            check("t3_busy", if0.busy, (s <= 15));
            check("t3_dv",   if0.dout_valid, (s >= 11 && s <= 15));
            check("t3_di",   {if0.dout_i}, (s >= 11 && s <= 15) ? beat16(s - 11, 1'b0) : '0);
        end
        check("t3_phase", u0.phase, 0);

        // Beat with flush, beat during FLUSH: both dropped, ovr_err sticky until clr.
        do_reset();
        for (int b = 0; b < 3; b++) drive0(1'b1, b, 1'b0);
        drive0(1'b1, 99, 1'b1);
        drive0(1'b1, 100, 1'b0);
        check("t4_busy", if0.busy, 1'b1);
        check("t4_ovr",  if0.ovr_err, 1'b1);
        idx  = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            drive0(1'b0, 0, 1'b0);
            if (if0.dout_valid) begin
                check("t4_di", {if0.dout_i}, beat16(idx, 1'b0));
                idx++;
            end
            if (!if0.busy) done = 1'b1;
        end
        check("t4_flush_end", if0.busy, 1'b0);
        check("t4_nbeats",    idx, 3);
        check("t4_ovr_held",  if0.ovr_err, 1'b1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("t4_ovr_clr", if0.ovr_err, 1'b0);

        // Asynchronous reset in the middle of FLUSH.
        do_reset();
        for (int b = 0; b < 20; b++) drive0(1'b1, b, 1'b0);
        drive0(1'b0, 0, 1'b1);
        drive0(1'b0, 0, 1'b0);
        drive0(1'b0, 0, 1'b0);
        check("t5_pre_dv",   if0.dout_valid, 1'b1);
        check("t5_pre_busy", if0.busy, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("t5_rst_dv",    if0.dout_valid, 1'b0);
        check("t5_rst_di",    {if0.dout_i}, '0);
        check("t5_rst_dq",    {if0.dout_q}, '0);
        check("t5_rst_busy",  if0.busy, 1'b0);
        check("t5_rst_phase", u0.phase, 0);
        @(negedge clk);
        rstn = 1'b1;
        drive0(1'b1, 0, 1'b0);
        check("t5_restart_bfly", if0.bfly_en, 1'b0);
        drive0(1'b0, 0, 1'b0);
        check("t5_restart_phase", u0.phase, 1);

        // Synchronous clear mid-frame overrides a simultaneous beat and flush.
        for (int b = 1; b <= 20; b++) drive0(1'b1, b, 1'b0);
        check("t6_pre_dv", if0.dout_valid, 1'b1);
        @(negedge clk);
        clr           = 1'b1;
        if0.din_valid = 1'b1;
        if0.flush     = 1'b1;
        @(negedge clk);
        clr           = 1'b0;
        if0.din_valid = 1'b0;
        if0.flush     = 1'b0;
        #1;
        check("t6_clr_dv",    if0.dout_valid, 1'b0);
        check("t6_clr_di",    {if0.dout_i}, '0);
        check("t6_clr_busy",  if0.busy, 1'b0);
        check("t6_clr_ovr",   if0.ovr_err, 1'b0);
        check("t6_clr_phase", u0.phase, 0);
        drive0(1'b1, 0, 1'b0);
        check("t6_restart_bfly", if0.bfly_en, 1'b0);
        drive0(1'b0, 0, 1'b0);
        check("t6_restart_phase", u0.phase, 1);
        check("t6_restart_busy",  if0.busy, 1'b0);

        // Parameter sweep: BLOCKS=8 and BLOCKS=64 under continuous input.
        do_reset();
        for (int b = 0; b < 132; b++) begin
            @(negedge clk);
            if1.din_valid = 1'b1;
            if1.din_i     = pat4(b);
            if1.din_q     = pat4(b + 7);
            if2.din_valid = 1'b1;
            if2.din_i     = pat8(b);
            if2.din_q     = pat8(b + 7);
            #1;
            check("sw4_bfly", if1.bfly_en, ((b % 16) >= 8));
            check("sw4_dv",   if1.dout_valid, (b >= 8));
            if (b >= 8) begin
                check("sw4_di", {if1.dout_i}, pat4(b - 8));
                check("sw4_dq", {if1.dout_q}, pat4(b - 8 + 7));
            end
            check("sw8_bfly", if2.bfly_en, ((b % 128) >= 64));
            check("sw8_dv",   if2.dout_valid, (b >= 64));
            if (b >= 64) begin
                check("sw8_di", {if2.dout_i}, pat8(b - 64));
                check("sw8_dq", {if2.dout_q}, pat8(b - 64 + 7));
            end
        end
        @(negedge clk);
        if1.din_valid = 1'b0;
        if2.din_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
